// File: rtl/rom_load_pkg.sv
// Shared types and region-base helper for the ROM load sequencer.
// Region order is fixed: program ROM, graphics ROM, sync PROM, packed from address 0.
package rom_load_pkg;

    localparam int ADDR_W    = 25;
    localparam int DN_ADDR_W = 17;

    typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, ERR} state_t;

    typedef enum logic [1:0] {REG_PROG, REG_GFX, REG_PROM, REG_NONE} region_t;

    // REG_NONE yields the end of the image, i.e. the first out-of-range address.
    function automatic logic [ADDR_W-1:0] region_base(
        input region_t r,
        input int      prog_bytes,
        input int      gfx_bytes,
        input int      prom_bytes
    );
        logic [ADDR_W-1:0] b;
        case (r)
            REG_PROG: b = '0;
            REG_GFX:  b = ADDR_W'(prog_bytes);
            REG_PROM: b = ADDR_W'(prog_bytes + gfx_bytes);
            default:  b = ADDR_W'(prog_bytes + gfx_bytes + prom_bytes);
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rom_load_sequencer_decode.sv
// Combinational decode of an ioctl byte address into a ROM region and region-local offset.
// Addresses at or past the end of the image decode to REG_NONE.
module rom_region_decode
    import rom_load_pkg::*;
#(
    parameter int PROG_BYTES = 4096,
    parameter int GFX_BYTES  = 2048,
    parameter int PROM_BYTES = 256
) (
    input  logic [ADDR_W-1:0]    i_addr,
    output region_t              o_region,
    output logic [DN_ADDR_W-1:0] o_offset
);

    localparam logic [ADDR_W-1:0] GFX_BASE  = region_base(REG_GFX,  PROG_BYTES, GFX_BYTES, PROM_BYTES);
    localparam logic [ADDR_W-1:0] PROM_BASE = region_base(REG_PROM, PROG_BYTES, GFX_BYTES, PROM_BYTES);
    localparam logic [ADDR_W-1:0] END_ADDR  = region_base(REG_NONE, PROG_BYTES, GFX_BYTES, PROM_BYTES);

    always_comb begin
        o_region = REG_NONE;
        o_offset = '0;
        if (i_addr < GFX_BASE) begin
            o_region = REG_PROG;
            o_offset = DN_ADDR_W'(i_addr);
        end else if (i_addr < PROM_BASE) begin
            o_region = REG_GFX;
            o_offset = DN_ADDR_W'(i_addr - GFX_BASE);
        end else if (i_addr < END_ADDR) begin
            o_region = REG_PROM;
            o_offset = DN_ADDR_W'(i_addr - PROM_BASE);
        end
    end

endmodule

// File: rtl/rom_load_sequencer.sv
// Routes the HPS ioctl download into the game ROMs and holds the game in reset until a
// complete image has settled. Define ROM_LOAD_CHECKSUM_EN to also require a 16-bit byte sum.
//   state | meaning
//   IDLE  | no image resident, game held in reset
//   LOAD  | download window open, bytes routed to ROMs
//   HOLD  | good image, game kept in reset for HOLD_CYCLES
//   RUN   | game released, image resident
//   ERR   | last download short (or bad sum), game held in reset
module rom_load_sequencer
    import rom_load_pkg::*;
#(
    parameter int          PROG_BYTES  = 4096,
    parameter int          GFX_BYTES   = 2048,
    parameter int          PROM_BYTES  = 256,
    parameter int          HOLD_CYCLES = 1024,
    parameter logic [15:0] EXP_SUM     = 16'h0000
) (
    input  logic                 clk_sys,
    input  logic                 Reset_n,
    input  logic                 ioctl_download,
    input  logic                 ioctl_wr,
    input  logic [ADDR_W-1:0]    ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic [DN_ADDR_W-1:0] dn_addr,
    output logic [7:0]           dn_data,
    output logic                 prog_we,
    output logic                 gfx_we,
    output logic                 prom_we,
    output logic                 game_reset_n,
    output logic                 load_done,
    output logic                 load_err
);

    localparam int TOTAL  = PROG_BYTES + GFX_BYTES + PROM_BYTES;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  TOTAL_C   = CNT_W'(TOTAL);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_dl_q;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_base;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [HOLD_W-1:0]    r_hold;
    logic [DN_ADDR_W-1:0] r_dn_addr;
    logic [7:0]           r_dn_data;
    logic                 r_prog_we;
    logic                 r_gfx_we;
    logic                 r_prom_we;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_entering;
    logic                 w_accept;
    logic                 w_len_ok;
    logic                 w_sum_ok;
    region_t              w_region;
    logic [DN_ADDR_W-1:0] w_offset;

    rom_region_decode #(
        .PROG_BYTES (PROG_BYTES),
        .GFX_BYTES  (GFX_BYTES),
        .PROM_BYTES (PROM_BYTES)
    ) u_decode (
        .i_addr   (ioctl_addr),
        .o_region (w_region),
        .o_offset (w_offset)
    );

    assign w_rise = ioctl_download && !r_dl_q;
    assign w_fall = !ioctl_download && r_dl_q;

    // The write on the rising-edge cycle belongs to the new load, so counting restarts from zero.
    assign w_entering = (w_state_next == LOAD) && (r_state != LOAD);
    assign w_accept   = ioctl_wr && (w_region != REG_NONE) && ((r_state == LOAD) || w_entering);
    assign w_cnt_base = w_entering ? '0 : r_cnt;
    assign w_cnt_next = (w_accept && (w_cnt_base != TOTAL_C)) ? w_cnt_base + CNT_W'(1) : w_cnt_base;
    assign w_len_ok   = (w_cnt_next == TOTAL_C);

`ifdef ROM_LOAD_CHECKSUM_EN
    logic [15:0] r_sum;
    logic [15:0] w_sum_base;
    logic [15:0] w_sum_next;

    assign w_sum_base = w_entering ? '0 : r_sum;
    assign w_sum_next = w_accept ? w_sum_base + {8'h00, ioctl_dout} : w_sum_base;
    assign w_sum_ok   = (w_sum_next == EXP_SUM);

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) r_sum <= '0;
        else          r_sum <= w_sum_next;
    end
`else
    assign w_sum_ok = 1'b1;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD: begin
                if (w_fall) w_state_next = (w_len_ok && w_sum_ok) ? HOLD : ERR;
            end
            HOLD: begin
                if (w_rise)              w_state_next = LOAD;
                else if (r_hold == '0)   w_state_next = RUN;
            end
            default: begin
                if (w_rise) w_state_next = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_dl_q  <= 1'b0;
            r_cnt   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_next;
            r_dl_q  <= ioctl_download;
            r_cnt   <= w_cnt_next;
            if ((w_state_next == HOLD) && (r_state != HOLD)) r_hold <= HOLD_LOAD;
            else if ((r_state == HOLD) && (r_hold != '0))    r_hold <= r_hold - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            r_dn_addr <= '0;
            r_dn_data <= '0;
            r_prog_we <= 1'b0;
            r_gfx_we  <= 1'b0;
            r_prom_we <= 1'b0;
        end else begin
            r_prog_we <= w_accept && (w_region == REG_PROG);
            r_gfx_we  <= w_accept && (w_region == REG_GFX);
            r_prom_we <= w_accept && (w_region == REG_PROM);
            if (w_accept) begin
                r_dn_addr <= w_offset;
                r_dn_data <= ioctl_dout;
            end
        end
    end

    assign dn_addr = r_dn_addr;
    assign dn_data = r_dn_data;
    assign prog_we = r_prog_we;
    assign gfx_we  = r_gfx_we;
    assign prom_we = r_prom_we;

    // A redownload pulls the game back into reset in the very cycle the edge is seen.
    assign game_reset_n = (r_state == RUN) && !w_rise;
    assign load_done    = (r_state == RUN) && !w_rise;
    assign load_err     = (r_state == ERR);

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Scoreboard bench for rom_load_sequencer: each routed byte is queued when driven and
// matched against the strobe it produces; state behaviour is checked through the outputs.
module tb_rom_load_sequencer;

    localparam int PROG  = 4096;
    localparam int GFX   = 2048;
    localparam int PROM  = 256;
    localparam int TOTAL = PROG + GFX + PROM;
    localparam int HOLD  = 1024;

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 37 + 11) ^ (a >> 8));
    endfunction

`ifdef ROM_LOAD_CHECKSUM_EN
    function automatic logic [15:0] pat_sum(input int n);
        logic [15:0] s;
        s = '0;
        for (int k = 0; k < n; k++) s = s + {8'h00, pat(k)};
        return s;
    endfunction
    localparam logic [15:0] EXP = pat_sum(TOTAL);
`else
    localparam logic [15:0] EXP = 16'h0000;
`endif

    typedef struct packed {
        logic [2:0]  we;
        logic [16:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk_sys;
    logic        Reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [16:0] dn_addr;
    logic [7:0]  dn_data;
    logic        prog_we;
    logic        gfx_we;
    logic        prom_we;
    logic        game_reset_n;
    logic        load_done;
    logic        load_err;

    wr_t sb[$];
    int  n_pass;
    int  n_total;
    int  cnt_prog;
    int  cnt_gfx;
    int  cnt_prom;
    int  gfx_first_addr;

    rom_load_sequencer #(
        .PROG_BYTES  (PROG),
        .GFX_BYTES   (GFX),
        .PROM_BYTES  (PROM),
        .HOLD_CYCLES (HOLD),
        .EXP_SUM     (EXP)
    ) dut (
        .clk_sys        (clk_sys),
        .Reset_n        (Reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .prog_we        (prog_we),
        .gfx_we         (gfx_we),
        .prom_we        (prom_we),
        .game_reset_n   (game_reset_n),
        .load_done      (load_done),
        .load_err       (load_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    function automatic wr_t expect_wr(input int a, input logic [7:0] d);
        wr_t e;
        e.data = d;
        if (a < PROG) begin
            e.we = 3'b001; e.addr = 17'(a);
        end else if (a < PROG + GFX) begin
            e.we = 3'b010; e.addr = 17'(a - PROG);
        end else begin
            e.we = 3'b100; e.addr = 17'(a - PROG - GFX);
        end
        return e;
    endfunction

    // Drives n in-range bytes (plus 101 out-of-range ones when extra), one per cycle, opening
    // the window with the first byte and closing it with the last unless keep_high.
    // Returns at the negedge of the cycle that follows the falling-edge detection.
    task automatic run_load(input int n, input bit extra, input bit bias, input bit chk_rise,
                            input bit keep_high);
        int   cnt;
        int   a;
        logic [7:0] d;
        wr_t  e;
        wr_t  got;
        cnt_prog = 0; cnt_gfx = 0; cnt_prom = 0; gfx_first_addr = -1;
        cnt = n + (extra ? 101 : 0);
        for (int i = 0; i <= cnt; i++) begin
            @(posedge clk_sys); #1;
            if (i < cnt) begin
                a = (i < n) ? i : TOTAL + (i - n);
                d = pat(a) + ((bias && a == 0) ? 8'd1 : 8'd0);
                ioctl_download = keep_high || (i != cnt - 1);
                ioctl_wr   = 1'b1;
                ioctl_addr = 25'(a);
                ioctl_dout = d;
                if (a < TOTAL) sb.push_back(expect_wr(a, d));
            end else begin
                ioctl_wr = 1'b0;
            end
            if (i == 0 && chk_rise) begin
                #2;
                n_total++;
                if (game_reset_n !== 1'b0 || load_done !== 1'b0)
                    $display("FAIL rise_reset_drop: got game_reset_n=%b load_done=%b expected 0 0",
                             game_reset_n, load_done);
                else n_pass++;
            end
            @(negedge clk_sys);
            if (prog_we || gfx_we || prom_we) begin
                n_total++;
                got = {prom_we, gfx_we, prog_we, dn_addr, dn_data};
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_strobe: got %h expected no strobe", got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) $display("FAIL strobe_data: got %h expected %h", got, e);
                    else n_pass++;
                end
                if (gfx_we && gfx_first_addr < 0) gfx_first_addr = int'(dn_addr);
                cnt_prog += int'(prog_we);
                cnt_gfx  += int'(gfx_we);
                cnt_prom += int'(prom_we);
            end
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL missing_strobes: got %0d pending expected 0", sb.size());
        else n_pass++;
    endtask

    // Entered at the negedge of the cycle after falling-edge detection (first HOLD cycle).
    task automatic check_hold();
        n_total++;
        if (game_reset_n !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0)
            $display("FAIL hold_entry: got rst_n=%b done=%b err=%b expected 0 0 0",
                     game_reset_n, load_done, load_err);
        else n_pass++;
        repeat (HOLD - 1) @(posedge clk_sys);
        @(negedge clk_sys);
        n_total++;
        if (game_reset_n !== 1'b0)
            $display("FAIL hold_last_cycle: got game_reset_n=%b expected 0", game_reset_n);
        else n_pass++;
        @(posedge clk_sys);
        @(negedge clk_sys);
        n_total++;
        if (game_reset_n !== 1'b1 || load_done !== 1'b1 || load_err !== 1'b0)
            $display("FAIL run_after_hold: got rst_n=%b done=%b err=%b expected 1 1 0",
                     game_reset_n, load_done, load_err);
        else n_pass++;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
        repeat (3) @(negedge clk_sys);
        n_total++;
        if ({dn_addr, dn_data, prog_we, gfx_we, prom_we, game_reset_n, load_done, load_err} !== '0)
            $display("FAIL reset_values: got %h %h %b%b%b %b %b %b expected all 0",
                     dn_addr, dn_data, prog_we, gfx_we, prom_we, game_reset_n, load_done, load_err);
        else n_pass++;
        @(posedge clk_sys); #1;
        Reset_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        n_total++;
        if (game_reset_n !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0)
            $display("FAIL idle_after_reset: got rst_n=%b done=%b err=%b expected 0 0 0",
                     game_reset_n, load_done, load_err);
        else n_pass++;
    endtask

    task automatic test_full_load();
        run_load(TOTAL, 1'b0, 1'b0, 1'b0, 1'b0);
        check_hold();
        n_total++;
        if (cnt_prog != PROG || cnt_gfx != GFX || cnt_prom != PROM)
            $display("FAIL region_counts: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     cnt_prog, cnt_gfx, cnt_prom, PROG, GFX, PROM);
        else n_pass++;
        n_total++;
        if (gfx_first_addr != 0)
            $display("FAIL gfx_first_addr: got %0d expected 0", gfx_first_addr);
        else n_pass++;
    endtask

    task automatic test_short_load();
        run_load(TOTAL - 1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (load_err !== 1'b1 || game_reset_n !== 1'b0 || load_done !== 1'b0)
            $display("FAIL short_err: got err=%b rst_n=%b done=%b expected 1 0 0",
                     load_err, game_reset_n, load_done);
        else n_pass++;
        repeat (HOLD + 50) @(posedge clk_sys);
        @(negedge clk_sys);
        n_total++;
        if (load_err !== 1'b1 || game_reset_n !== 1'b0)
            $display("FAIL short_stays_err: got err=%b rst_n=%b expected 1 0", load_err, game_reset_n);
        else n_pass++;
        run_load(TOTAL, 1'b0, 1'b0, 1'b0, 1'b0);
        check_hold();
    endtask

    task automatic test_extra_bytes();
        run_load(TOTAL, 1'b1, 1'b0, 1'b0, 1'b0);
        check_hold();
        n_total++;
        if (cnt_prog + cnt_gfx + cnt_prom != TOTAL)
            $display("FAIL extra_strobe_count: got %0d expected %0d",
                     cnt_prog + cnt_gfx + cnt_prom, TOTAL);
        else n_pass++;
    endtask

    task automatic test_redownload();
        run_load(TOTAL, 1'b0, 1'b0, 1'b1, 1'b0);
        check_hold();
    endtask

    task automatic test_reset_mid_load();
        run_load(100, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b1; ioctl_addr = 25'd100; ioctl_dout = pat(100);
        @(negedge clk_sys); #1;
        Reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            n_total++;
            if ({dn_addr, dn_data, prog_we, gfx_we, prom_we, game_reset_n, load_done, load_err} !== '0)
                $display("FAIL mid_load_reset: got %h %h %b%b%b %b %b %b expected all 0",
                         dn_addr, dn_data, prog_we, gfx_we, prom_we, game_reset_n, load_done, load_err);
            else n_pass++;
        end
        @(posedge clk_sys); #1;
        ioctl_download = 1'b0; ioctl_wr = 1'b0;
        Reset_n = 1'b1;
        repeat (HOLD + 10) @(posedge clk_sys);
        @(negedge clk_sys);
        n_total++;
        if ({prog_we, gfx_we, prom_we, game_reset_n, load_done, load_err} !== '0)
            $display("FAIL idle_after_mid_reset: got %b%b%b %b %b %b expected all 0",
                     prog_we, gfx_we, prom_we, game_reset_n, load_done, load_err);
        else n_pass++;
        run_load(TOTAL, 1'b0, 1'b0, 1'b0, 1'b0);
        check_hold();
    endtask

`ifdef ROM_LOAD_CHECKSUM_EN
    task automatic test_checksum();
        run_load(TOTAL, 1'b0, 1'b1, 1'b0, 1'b0);
        n_total++;
        if (load_err !== 1'b1 || game_reset_n !== 1'b0)
            $display("FAIL sum_mismatch_err: got err=%b rst_n=%b expected 1 0", load_err, game_reset_n);
        else n_pass++;
        run_load(TOTAL, 1'b0, 1'b0, 1'b0, 1'b0);
        check_hold();
    endtask
`endif

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_full_load();
        test_short_load();
        test_extra_bytes();
        test_redownload();
        test_reset_mid_load();
`ifdef ROM_LOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
